// File: rtl/thunderbolt_pkg.sv
// Shared constants for the Thunderbolt TSIP timing path: framing bytes,
// packet identifiers, capture offsets and the framing FSM state encoding.
package thunderbolt_pkg;

  localparam logic [7:0] c_DLE         = 8'h10;
  localparam logic [7:0] c_ETX         = 8'h03;
  localparam logic [7:0] c_ID_TIMING   = 8'h8F;
  localparam logic [7:0] c_SUB_PRIMARY = 8'hAB;

  // Unstuffed payload bytes after the ID, subcode included (subcode is index 0).
  localparam int         c_PKT_LEN     = 17;
  localparam int         c_IDX_W       = 5;
  localparam logic [c_IDX_W-1:0] c_PKT_LEN_IDX = c_IDX_W'(c_PKT_LEN);

  // Big-endian byte offsets of the fields kept from a Primary Timing packet.
  localparam logic [c_IDX_W-1:0] c_OFF_UTC_HI  = 5'd7;
  localparam logic [c_IDX_W-1:0] c_OFF_UTC_LO  = 5'd8;
  localparam logic [c_IDX_W-1:0] c_OFF_SECONDS = 5'd10;
  localparam logic [c_IDX_W-1:0] c_OFF_MINUTES = 5'd11;
  localparam logic [c_IDX_W-1:0] c_OFF_HOUR    = 5'd12;
  localparam logic [c_IDX_W-1:0] c_OFF_DAY     = 5'd13;
  localparam logic [c_IDX_W-1:0] c_OFF_MONTH   = 5'd14;
  localparam logic [c_IDX_W-1:0] c_OFF_YEAR_HI = 5'd15;
  localparam logic [c_IDX_W-1:0] c_OFF_YEAR_LO = 5'd16;

  // Framing FSM encoding, also decoded by UART/debug logic.
  typedef enum logic [2:0] {
    s_IDLE     = 3'd0,
    s_ID       = 3'd1,
    s_SUB      = 3'd2,
    s_DATA     = 3'd3,
    s_DLE      = 3'd4,
    s_SKIP     = 3'd5,
    s_SKIP_DLE = 3'd6
  } tsip_state_t;

endpackage

// File: rtl/thunderbolt_timing_parser_unstuffer.sv
// TSIP framing: DLE removal, packet delimiting and 0x8F-AB header match.
//
//   state      | meaning
//   s_IDLE     | outside any packet, waiting for DLE
//   s_ID       | DLE seen, next byte is the packet ID
//   s_SUB      | ID 0x8F seen, next byte is the subcode
//   s_DATA     | inside a Primary Timing payload
//   s_DLE      | DLE seen inside payload (stuffed DLE or end of packet)
//   s_SKIP     | inside a foreign or overflowed packet, discarding
//   s_SKIP_DLE | DLE seen while discarding
//
// Strobes are combinational on the accepted input byte; the parent registers
// everything it drives out. `abort` (overflow) sends the frame to s_SKIP.
module tsip_unstuffer
  import thunderbolt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       abort,
  output logic       byte_dv,
  output logic [7:0] data,
  output logic       sop,
  output logic       eop,
  output logic       err
);

  tsip_state_t state;

  logic is_dle;
  logic is_etx;

  assign is_dle  = (rx_byte == c_DLE);
  assign is_etx  = (rx_byte == c_ETX);
  assign data    = rx_byte;
  assign sop     = rx_dv && (state == s_SUB) && (rx_byte == c_SUB_PRIMARY);
  assign byte_dv = rx_dv && (((state == s_DATA) && !is_dle) ||
                             ((state == s_DLE) && is_dle));
  assign eop     = rx_dv && (state == s_DLE) && is_etx;
  assign err     = rx_dv && (state == s_DLE) && !is_dle && !is_etx;

  // Framing state advances only on accepted bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_IDLE;
    end else if (rx_dv) begin
      unique case (state)
        s_IDLE:     if (is_dle) state <= s_ID;
        s_ID: begin
          if (rx_byte == c_ID_TIMING) state <= s_SUB;
          else if (is_dle || is_etx)  state <= s_IDLE;
          else                        state <= s_SKIP;
        end
        s_SUB:      state <= (rx_byte == c_SUB_PRIMARY) ? s_DATA : s_SKIP;
        s_DATA: begin
          if (is_dle)     state <= s_DLE;
          else if (abort) state <= s_SKIP;
        end
        s_DLE: begin
          if (is_dle) state <= abort ? s_SKIP : s_DATA;
          else        state <= s_IDLE;
        end
        s_SKIP:     if (is_dle) state <= s_SKIP_DLE;
        s_SKIP_DLE: state <= is_dle ? s_SKIP : s_IDLE;
        default:    state <= s_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/thunderbolt_timing_parser.sv
// Decodes TSIP Primary Timing packets (0x8F-AB) into UTC date/time fields.
// Fields are captured into shadow registers and copied to the outputs only
// when a correctly framed packet of the right length ends.
// Optional build macro THUNDER_RANGE_CHECK_EN: reject commits whose
// date/time fields are out of range (reported as a frame error instead).
module thunderbolt_timing_parser
  import thunderbolt_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_packet_dv,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic [15:0] o_utc_offset,
  output logic        o_frame_err
);

  logic               byte_dv;
  logic [7:0]         data;
  logic               sop;
  logic               eop;
  logic               err;
  logic               overflow;
  logic               range_ok;
  logic               commit;
  logic               frame_err_next;
  logic [c_IDX_W-1:0] index;

  logic [15:0] sh_year;
  logic [7:0]  sh_month;
  logic [7:0]  sh_day;
  logic [7:0]  sh_hour;
  logic [7:0]  sh_minutes;
  logic [7:0]  sh_seconds;
  logic [15:0] sh_utc_offset;

  tsip_unstuffer u_unstuffer (
    .clk     (i_clk),
    .rst     (i_rst),
    .rx_dv   (i_rx_dv),
    .rx_byte (i_rx_byte),
    .abort   (overflow),
    .byte_dv (byte_dv),
    .data    (data),
    .sop     (sop),
    .eop     (eop),
    .err     (err)
  );

  // A payload byte arriving with the buffer already full is an overflow.
  assign overflow = byte_dv && (index == c_PKT_LEN_IDX);

`ifdef THUNDER_RANGE_CHECK_EN
  assign range_ok = (sh_month >= 8'd1) && (sh_month <= 8'd12) &&
                    (sh_day   >= 8'd1) && (sh_day   <= 8'd31) &&
                    (sh_hour <= 8'd23) && (sh_minutes <= 8'd59) &&
                    (sh_seconds <= 8'd60);
`else
  assign range_ok = 1'b1;
`endif

  assign commit         = eop && (index == c_PKT_LEN_IDX) && range_ok;
  assign frame_err_next = overflow || err || (eop && !commit);

  // Index counter and shadow capture of the fields of interest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      index         <= '0;
      sh_year       <= '0;
      sh_month      <= '0;
      sh_day        <= '0;
      sh_hour       <= '0;
      sh_minutes    <= '0;
      sh_seconds    <= '0;
      sh_utc_offset <= '0;
    end else if (sop) begin
      index <= 5'd1;
    end else if (byte_dv && !overflow) begin
      index <= index + 5'd1;
      unique case (index)
        c_OFF_UTC_HI:  sh_utc_offset[15:8] <= data;
        c_OFF_UTC_LO:  sh_utc_offset[7:0]  <= data;
        c_OFF_SECONDS: sh_seconds          <= data;
        c_OFF_MINUTES: sh_minutes          <= data;
        c_OFF_HOUR:    sh_hour             <= data;
        c_OFF_DAY:     sh_day              <= data;
        c_OFF_MONTH:   sh_month            <= data;
        c_OFF_YEAR_HI: sh_year[15:8]       <= data;
        c_OFF_YEAR_LO: sh_year[7:0]        <= data;
        default:       ;
      endcase
    end
  end

  // Registered strobes and commit of shadow fields to the outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_packet_dv  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_year       <= '0;
      o_month      <= '0;
      o_day        <= '0;
      o_hour       <= '0;
      o_minutes    <= '0;
      o_seconds    <= '0;
      o_utc_offset <= '0;
    end else begin
      o_packet_dv <= commit;
      o_frame_err <= frame_err_next;
      if (commit) begin
        o_year       <= sh_year;
        o_month      <= sh_month;
        o_day        <= sh_day;
        o_hour       <= sh_hour;
        o_minutes    <= sh_minutes;
        o_seconds    <= sh_seconds;
        o_utc_offset <= sh_utc_offset;
      end
    end
  end

endmodule

// File: tb/tb_thunderbolt_timing_parser.sv
// Scoreboard bench for thunderbolt_timing_parser: the driver pushes the
// expected strobe (kind, cycle, field values) per packet; a monitor pops and
// compares whenever the DUT strobes.
module tb_thunderbolt_timing_parser;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_packet_dv;
  logic [15:0] o_year;
  logic [7:0]  o_month;
  logic [7:0]  o_day;
  logic [7:0]  o_hour;
  logic [7:0]  o_minutes;
  logic [7:0]  o_seconds;
  logic [15:0] o_utc_offset;
  logic        o_frame_err;

  thunderbolt_timing_parser dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .o_packet_dv  (o_packet_dv),
    .o_year       (o_year),
    .o_month      (o_month),
    .o_day        (o_day),
    .o_hour       (o_hour),
    .o_minutes    (o_minutes),
    .o_seconds    (o_seconds),
    .o_utc_offset (o_utc_offset),
    .o_frame_err  (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int          at;
    logic [71:0] fields;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [71:0] cur;
  int          total = 0;
  int          bad   = 0;
  int          last_cyc = 0;
  logic [7:0]  pl [1:17];
  logic [7:0]  frm[$];

  function automatic logic [71:0] mk(input logic [15:0] year, input logic [7:0] month,
                                     input logic [7:0] day, input logic [7:0] hour,
                                     input logic [7:0] minutes, input logic [7:0] seconds,
                                     input logic [15:0] off);
    return {year, month, day, hour, minutes, seconds, off};
  endfunction

  // Monitor: compare every strobe against the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst && (o_packet_dv || o_frame_err)) begin
      total++;
      if (o_packet_dv && o_frame_err) begin
        bad++;
        $display("FAIL strobes_both cyc=%0d dv=1 err=1 required one of them", cyc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d dv=%0d err=%0d required none", cyc, o_packet_dv, o_frame_err);
      end else begin
        e = sb.pop_front();
        if (o_frame_err != e.is_err || cyc != e.at) begin
          bad++;
          $display("FAIL strobe_kind cyc=%0d err=%0d required err=%0d at cyc=%0d", cyc, o_frame_err, e.is_err, e.at);
        end
        total++;
        if ({o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_utc_offset} != e.fields) begin
          bad++;
          $display("FAIL fields cyc=%0d got=%h required=%h", cyc,
                   {o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_utc_offset}, e.fields);
        end
      end
    end
    while (sb.size() > 0 && sb[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_strobe cyc=%0d got none required err=%0d at cyc=%0d", cyc, sb[0].is_err, sb[0].at);
      void'(sb.pop_front());
    end
  end

  task automatic push_exp(input bit is_err);
    exp_t x;
    x.is_err = is_err;
    x.at     = last_cyc + 1;
    x.fields = cur;
    sb.push_back(x);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_utc_offset, o_packet_dv, o_frame_err} != '0) begin
      bad++;
      $display("FAIL %s got=%h required=0", name,
               {o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_utc_offset, o_packet_dv, o_frame_err});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    last_cyc  = cyc;
  endtask

  // Idle cycles keep a DLE on the bus so an ignored strobe qualifier shows up.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h10;
    end
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic set_payload(input logic [7:0] month, input logic [7:0] sec, input logic [15:0] year);
    pl[1] = 8'h00; pl[2] = 8'h01; pl[3] = 8'h02; pl[4] = 8'h03;
    pl[5] = 8'h08; pl[6] = 8'hC4; pl[7] = 8'h00; pl[8] = 8'h12;
    pl[9] = 8'h03; pl[10] = sec;  pl[11] = 8'h22; pl[12] = 8'h0C;
    pl[13] = 8'h0F; pl[14] = month; pl[15] = year[15:8]; pl[16] = year[7:0];
    pl[17] = 8'h55;
  endtask

  task automatic build(input int ndata, input bit trailer);
    frm.delete();
    frm.push_back(8'h10); frm.push_back(8'h8F); frm.push_back(8'hAB);
    for (int i = 1; i <= ndata; i++) begin
      frm.push_back(pl[i]);
      if (pl[i] == 8'h10) frm.push_back(8'h10);
    end
    if (trailer) begin
      frm.push_back(8'h10); frm.push_back(8'h03);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00;
    cur = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("reset_state");
    i_rst = 1'b0;
    idle(3);

    // Valid packet.
    set_payload(8'h03, 8'h38, 16'h07E8);
    build(16, 1'b1);
    send_frame();
    cur = mk(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56, 16'd18);
    push_exp(1'b0);
    idle(4);

    // Stuffed DLE inside TOW.
    pl[1] = 8'h00; pl[2] = 8'h00; pl[3] = 8'h10; pl[4] = 8'h00;
    build(16, 1'b1);
    send_frame();
    push_exp(1'b0);
    idle(4);

    // Foreign packets, then a valid one with seconds 57.
    frm = '{8'h10, 8'h8F, 8'hAC, 8'h01, 8'h02, 8'h10, 8'h10, 8'h03, 8'h10, 8'h03,
            8'h10, 8'h47, 8'h10, 8'h10, 8'h05, 8'h10, 8'h03};
    send_frame();
    set_payload(8'h03, 8'h39, 16'h07E8);
    build(16, 1'b1);
    send_frame();
    cur = mk(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd57, 16'd18);
    push_exp(1'b0);
    idle(4);

    // Short packet: 16-byte payload including subcode.
    set_payload(8'h05, 8'h01, 16'h07EE);
    build(15, 1'b1);
    send_frame();
    push_exp(1'b1);
    idle(4);

    // Long packet: error on the 18th payload byte, trailer discarded.
    build(17, 1'b0);
    send_frame();
    push_exp(1'b1);
    frm = '{8'h10, 8'h03};
    send_frame();
    idle(4);

    // DLE followed by a non-framing byte inside the payload.
    frm = '{8'h10, 8'h8F, 8'hAB, 8'h00, 8'h01, 8'h10, 8'h05};
    send_frame();
    push_exp(1'b1);
    idle(4);

    // Month 13.
    set_payload(8'h0D, 8'h38, 16'h07E8);
    build(16, 1'b1);
    send_frame();
`ifdef THUNDER_RANGE_CHECK_EN
    push_exp(1'b1);
`else
    cur = mk(16'd2024, 8'd13, 8'd15, 8'd12, 8'd34, 8'd56, 16'd18);
    push_exp(1'b0);
`endif
    idle(4);

    // Valid again.
    set_payload(8'h03, 8'h38, 16'h07E8);
    build(16, 1'b1);
    send_frame();
    cur = mk(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56, 16'd18);
    push_exp(1'b0);
    idle(4);

    // Reset after 10 bytes of a packet, then a valid packet for 2025.
    set_payload(8'h03, 8'h38, 16'h07E9);
    build(16, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(frm[i]);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1; i_rx_dv = 1'b0;
    #2;
    check_zero("reset_async");
    @(posedge i_clk);
    #1;
    check_zero("reset_hold");
    i_rst = 1'b0;
    cur = '0;
    send_frame();
    cur = mk(16'd2025, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56, 16'd18);
    push_exp(1'b0);
    idle(6);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thunderbolt_timing_parser.md
# thunderbolt_timing_parser

Parses the byte stream from the Thunderbolt GPS UART receiver, decodes TSIP Primary Timing packets (ID 0x8F, subcode 0xAB), and presents UTC date/time fields with a one-cycle data-valid strobe. It sits directly upstream of the pulse generator and drives its `i_thunder_packet_dv` and `i_thunder_*` inputs. All other TSIP packets are discarded. Output fields change only on a fully validated packet.

## Interface
- `c_PKT_LEN`, 17: unstuffed payload bytes after the ID, including the subcode.
- `i_clk` in 1: system clock. Single clock domain.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_rx_dv` in 1: one-cycle strobe; `i_rx_byte` is valid this cycle.
- `i_rx_byte` in 8: received UART byte.
- `o_packet_dv` out 1: one-cycle strobe; new fields are valid.
- `o_year` out 16: four-digit year.
- `o_month` out 8: month, 1–12.
- `o_day` out 8: day of month, 1–31.
- `o_hour` out 8: hours, 0–23.
- `o_minutes` out 8: minutes, 0–59.
- `o_seconds` out 8: seconds, 0–60.
- `o_utc_offset` out 16: GPS–UTC offset, signed.
- `o_frame_err` out 1: one-cycle strobe on a malformed 0x8F-AB packet.

## Operation
- Reset: all outputs are 0, the FSM is in `s_IDLE`, and the byte index is 0.
- Bytes are processed only in cycles where `i_rx_dv`=1. All other cycles hold state.
- Framing: DLE=0x10, ETX=0x03. Inside a packet, DLE DLE unstuffs to one 0x10 data byte, and DLE ETX ends the packet.
- FSM states and transitions:
  - `s_IDLE`: 0x10 → `s_ID`. Any other byte is ignored.
  - `s_ID`: 0x8F → `s_SUB`. 0x10 or 0x03 → `s_IDLE`. Any other byte → `s_SKIP`.
  - `s_SUB`: 0xAB → `s_DATA` with index=1. Any other byte → `s_SKIP`.
  - `s_DATA`: 0x10 → `s_DLE`. Any other byte is stored at the current index, then the index increments.
  - `s_DLE`:
    - 0x10: store 0x10 at the index, increment the index, return to `s_DATA`.
    - 0x03 with index==`c_PKT_LEN`: commit, go to `s_IDLE`.
    - 0x03 with any other index: `o_frame_err`, go to `s_IDLE`.
    - Any other byte: `o_frame_err`, go to `s_IDLE`.
  - `s_SKIP`: 0x10 → `s_SKIP_DLE`. Any other byte stays in `s_SKIP`.
  - `s_SKIP_DLE`: 0x10 → `s_SKIP`. Any other byte (including 0x03) → `s_IDLE`.
- Overflow: a store attempted at index==`c_PKT_LEN` raises `o_frame_err` and goes to `s_SKIP`. The capture buffer is unchanged.
- Capture: bytes go into shadow registers at these big-endian offsets:
  - 7–8: UTC offset.
  - 10: seconds.
  - 11: minutes.
  - 12: hours.
  - 13: day.
  - 14: month.
  - 15–16: year.
  - Offsets 1–6 and 9 (TOW, week, flags) are consumed and not stored.
- Commit: shadow registers copy to the output registers, and `o_packet_dv` pulses.
- Partial or errored packets never alter the outputs. Output values hold until the next commit.

## Timing
- `o_packet_dv` and the updated fields appear in the cycle after the `i_rx_dv` cycle carrying the ETX. Latency is 1 clock.
- `o_frame_err` is registered and asserts the cycle after the offending byte.
- `o_packet_dv` and `o_frame_err` are never high together.
- Back-to-back `i_rx_dv` on every cycle is supported, with no stalls and no ready signal.
- Reset asserted mid-packet takes effect immediately (asynchronous). The packet in progress is lost. The first byte after reset release is evaluated from `s_IDLE`.

## Configuration
- Macro: `THUNDER_RANGE_CHECK_EN`.
- When defined, a commit first checks these ranges:
  - month 1–12
  - day 1–31
  - hour ≤23
  - minutes ≤59
  - seconds ≤60
- On any range failure, the commit is replaced by an `o_frame_err` pulse and the outputs are unchanged.
- When undefined, every correctly framed packet of correct length commits without checks.

## Structure
- Shared package (`thunderbolt_pkg`) holds:
  - the DLE, ETX, 0x8F and 0xAB constants;
  - the field byte offsets;
  - the FSM state encodings, shared with the UART/debug logic.
- One sub-module is natural: `tsip_unstuffer`. It handles DLE removal and frame delimiting, and emits `byte_dv`, `byte`, `sop` and `eop` strobes.
- The top level holds the ID/subcode check, the index counter, the shadow registers and the commit logic.

## Test plan
- **Valid packet:** send 10 8F AB 00 01 02 03 08 C4 00 12 03 38 22 0C 0F 03 07 E8 10 03.
  - One `o_packet_dv`, one cycle after the final byte.
  - Fields: year 2024, month 3, day 15, hour 12, minutes 34, seconds 56, UTC offset 18.
- **Stuffing:** TOW bytes 00 00 10 00, sent as 00 00 10 10 00.
  - Same commit as above.
  - The index reaches 17 and there is no `o_frame_err`.
- **Foreign packet:** send 10 8F AC … 10 03, then 10 47 10 10 05 10 03, then the valid packet.
  - Only the last packet produces `o_packet_dv`.
  - No `o_frame_err` is raised.
- **Short and long packets:** a 16-byte payload, then 10 03 → `o_frame_err`. An 18-byte payload → `o_frame_err` at byte 18.
  - In both cases the outputs keep their previous values.
- **Reset mid-packet:** assert `i_rst` after byte 10, then send the valid packet.
  - Outputs are 0 during reset.
  - A single commit follows with the correct fields.
- **Range check (`THUNDER_RANGE_CHECK_EN` defined):** the valid packet with month=13.
  - Result: `o_frame_err` and no `o_packet_dv`.
  - When the macro is undefined, the same packet commits with month 13.
